// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - main-memory block responder servicing cache fill and write-back requests
//
// Purpose: services block read (fill) and block write (write-back) requests
// from the cache controller out of an internal block store with fixed
// latencies. A combined request commits the write-back first, then the fill.
//
// Ports:
//   clk, rst_n    clock (rising edge) and synchronous active-low reset
//   mem_rd_en     fill request (sampled only when idle)
//   mem_wr_en     write-back request (sampled only when idle)
//   mem_rd_addr   fill block address
//   mem_wr_addr   write-back block address
//   mem_wr_blk    write-back block data
//   mem_busy      request in progress, new requests ignored
//   mem_done      one-cycle completion pulse
//   mem_rd_blk    fill data, valid while mem_done=1 on a read, held afterwards
module main_mem_responder #(
    parameter int PA_WIDTH  = 16,
    parameter int BLK_WIDTH = 128,
    parameter int MEM_BLKS  = 256,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [PA_WIDTH-1:0]  mem_rd_addr,
    input  logic [PA_WIDTH-1:0]  mem_wr_addr,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic                 mem_busy,
    output logic                 mem_done,
    output logic [BLK_WIDTH-1:0] mem_rd_blk
);

    localparam int BOFF   = $clog2(BLK_WIDTH / 8);
    localparam int IDXW   = $clog2(MEM_BLKS);
    localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW     = $clog2(MAXLAT) + 1;

    // The accepting edge counts as the first latency cycle, so the counter
    // is loaded with LAT-1 and the final cycle is the one seeing zero.
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 rd_pend;
    logic [IDXW-1:0]      rd_idx;
    logic [IDXW-1:0]      wr_idx;
    logic [BLK_WIDTH-1:0] wr_data;
    logic                 wr_commit;

    logic [BLK_WIDTH-1:0] store [MEM_BLKS];

    // Address bits outside the block index are ignored, so addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_rd_addr[PA_WIDTH-1:BOFF+IDXW], mem_rd_addr[BOFF-1:0],
                                mem_wr_addr[PA_WIDTH-1:BOFF+IDXW], mem_wr_addr[BOFF-1:0]};

    // Gated by rst_n so a reset landing on the commit edge aborts the write.
    assign wr_commit = rst_n && (state == WRITE) && (cnt == '0);

    // Store contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            store[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_busy   <= 1'b0;
            mem_done   <= 1'b0;
            mem_rd_blk <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_done <= 1'b0;
                    if (mem_rd_en || mem_wr_en) begin
                        rd_pend  <= mem_rd_en;
                        rd_idx   <= mem_rd_addr[BOFF+IDXW-1:BOFF];
                        wr_idx   <= mem_wr_addr[BOFF+IDXW-1:BOFF];
                        wr_data  <= mem_wr_blk;
                        mem_busy <= 1'b1;
                        if (mem_wr_en) begin
                            state <= WRITE;
                            cnt   <= WR_LOAD;
                        end else begin
                            state <= READ;
                            cnt   <= RD_LOAD;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == '0) begin
                        if (rd_pend) begin
                            state <= READ;
                            cnt   <= RD_LOAD;
                        end else begin
                            state    <= DONE;
                            cnt      <= '0;
                            mem_busy <= 1'b0;
                            mem_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READ: begin
                    if (cnt == '0) begin
                        // Any write of this request committed earlier, so the
                        // fill observes it.
                        mem_rd_blk <= store[rd_idx];
                        state      <= DONE;
                        cnt        <= '0;
                        mem_busy   <= 1'b0;
                        mem_done   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Requests present here are ignored; next acceptance is in IDLE.
                    mem_done <= 1'b0;
                    state    <= IDLE;
                    cnt      <= '0;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    mem_busy <= 1'b0;
                    mem_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - directed self-checking bench for main_mem_responder
module tb_main_mem_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [15:0]  mem_rd_addr;
    logic [15:0]  mem_wr_addr;
    logic [127:0] mem_wr_blk;
    logic         mem_busy;
    logic         mem_done;
    logic [127:0] mem_rd_blk;

    int checks = 0;
    int errors = 0;

    main_mem_responder #(
        .PA_WIDTH (16),
        .BLK_WIDTH(128),
        .MEM_BLKS (256),
        .RD_LAT   (4),
        .WR_LAT   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_blk (mem_wr_blk),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_rd_blk (mem_rd_blk)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure edges from acceptance to mem_done, then
    // let the DONE cycle retire back to IDLE.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [15:0] raddr, input logic [15:0] waddr,
                           input logic [127:0] blk, input int exp_lat);
        int n;
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        mem_rd_addr = raddr;
        mem_wr_addr = waddr;
        mem_wr_blk  = blk;
        step();
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        chk({tag, "_busy"}, {127'd0, mem_busy}, 128'd1);
        n = 0;
        while (!mem_done && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
        chk({tag, "_busy_in_done"}, {127'd0, mem_busy}, 128'd0);
    endtask

    initial begin
        int dones;
        logic [127:0] held;

        rst_n       = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_blk  = '0;

        // Reset
        step();
        step();
        rst_n = 1'b1;
        chk("rst_busy", {127'd0, mem_busy}, 128'd0);
        chk("rst_done", {127'd0, mem_done}, 128'd0);
        chk("rst_rd_blk", mem_rd_blk, 128'd0);

        // Write-only then read of the same block
        run_req("wr40", 1'b0, 1'b1, 16'h0000, 16'h0040, {16{8'hA5}}, 2);
        chk("wr40_rd_blk_unchanged", mem_rd_blk, 128'd0);
        step();
        chk("wr40_done_pulse", {127'd0, mem_done}, 128'd0);
        run_req("rd40", 1'b1, 1'b0, 16'h0040, 16'h0000, 128'd0, 4);
        chk("rd40_data", mem_rd_blk, {16{8'hA5}});
        step();

        // Combined write-back plus fill of the same block
        run_req("comb80", 1'b1, 1'b1, 16'h0080, 16'h0080, 128'h1234, 6);
        chk("comb80_data", mem_rd_blk, 128'h1234);
        step();

        // Aliasing: bit 12 lies above the block index
        run_req("wr10", 1'b0, 1'b1, 16'h0000, 16'h0010, 128'hBEEF, 2);
        step();
        run_req("rd1010", 1'b1, 1'b0, 16'h1010, 16'h0000, 128'd0, 4);
        chk("alias_data", mem_rd_blk, 128'hBEEF);
        step();

        // Request during busy is dropped
        held = 128'hBEEF;
        mem_wr_en   = 1'b1;
        mem_wr_addr = 16'h0050;
        mem_wr_blk  = 128'h5555;
        step();
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b1;
        mem_rd_addr = 16'h0020;
        dones = 0;
        step();
        mem_rd_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mem_done) dones++;
            step();
        end
        chk("drop_done_count", 128'(dones), 128'd1);
        chk("drop_busy_after", {127'd0, mem_busy}, 128'd0);
        chk("drop_rd_blk", mem_rd_blk, held);

        // Reset aborts an in-flight write-back
        run_req("wr30", 1'b0, 1'b1, 16'h0000, 16'h0030, 128'h1111, 2);
        step();
        mem_wr_en   = 1'b1;
        mem_wr_addr = 16'h0030;
        mem_wr_blk  = 128'hDEAD;
        step();
        mem_wr_en = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", {127'd0, mem_busy}, 128'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_done) dones++;
            step();
        end
        chk("abort_no_done", 128'(dones), 128'd0);
        run_req("rd30", 1'b1, 1'b0, 16'h0030, 16'h0000, 128'd0, 4);
        chk("abort_data", mem_rd_blk, 128'h1111);
        step();
        chk("final_done_low", {127'd0, mem_done}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
